// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: two half-adder stages plus a carry flop add one
// bit pair per clock and report the WIDTH-bit sum and final carry on done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             bit_valid,
  output logic             bit_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_out_q, bit_out_d;

  logic             s0, c0, sbit, c1, carry_next;
  logic [WIDTH-1:0] acc_shift;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned; a
    // missing default in always_comb is how latches sneak in.
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    carry_d     = carry_q;
    busy_d      = busy_q;
    done_d      = done_q;
    bit_valid_d = bit_valid_q;
    bit_out_d   = bit_out_q;

    // Full-add cell: half adder on the operand bits, half adder with the carry.
    s0         = a_sr_q[0] ^ b_sr_q[0];
    c0         = a_sr_q[0] & b_sr_q[0];
    sbit       = s0 ^ c_q;
    c1         = s0 & c_q;
    carry_next = c0 | c1;
    acc_shift  = (acc_q >> 1) | (WIDTH'(sbit) << (WIDTH - 1));

    unique case (state_q)
      IDLE, DONE: begin
        done_d      = 1'b0;
        bit_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d      = a_sr_q >> 1;
        b_sr_d      = b_sr_q >> 1;
        acc_d       = acc_shift;
        c_d         = carry_next;
        cnt_d       = cnt_q + CW'(1);
        bit_valid_d = 1'b1;
        bit_out_d   = sbit;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = acc_shift;
          carry_d = carry_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a cycle-timeline model built on plain a+b arithmetic.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [2];
  logic       st_v  [2];
  logic [7:0] a_v   [2];
  logic [7:0] b_v   [2];
  logic       busy_v[2];
  logic       done_v[2];
  logic       bv_v  [2];
  logic       bo_v  [2];
  logic       co_v  [2];
  logic [7:0] sum8;
  logic [0:0] sum1;
  logic [7:0] sum_w [2];

  assign sum_w[0] = sum8;
  assign sum_w[1] = {7'b0, sum1};

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_v[0]), .start(st_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum8), .carry_out(co_v[0]),
    .bit_valid(bv_v[0]), .bit_out(bo_v[0])
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(rst_v[1]), .start(st_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .carry_out(co_v[1]),
    .bit_valid(bv_v[1]), .bit_out(bo_v[1])
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  // Reference model: once an add is accepted, result bit i appears i+1 edges
  // later and the result lands WIDTH edges later.
  bit         en    [2] = '{0, 0};
  bit         m_run [2] = '{0, 0};
  int         m_k   [2] = '{0, 0};
  logic [8:0] m_tot [2];
  logic       e_busy[2], e_done[2], e_bv[2], e_bo[2], e_co[2];
  logic [7:0] e_sum [2];
  longint     cyc = 0;
  int         done_cnt[2] = '{0, 0};
  logic [7:0] cap8 = 8'h00;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic [7:0] mask;
      mask = 8'((9'h1 << width_of(d)) - 9'h1);
      if (rst_v[d]) begin
        en[d]     = 1;
        m_run[d]  = 0;
        e_busy[d] = 0; e_done[d] = 0; e_bv[d] = 0; e_bo[d] = 0;
        e_co[d]   = 0; e_sum[d]  = 8'h00;
      end else if (m_run[d]) begin
        m_k[d]++;
        e_bv[d] = 1;
        e_bo[d] = m_tot[d][m_k[d]-1];
        if (m_k[d] == width_of(d)) begin
          m_run[d]  = 0;
          e_done[d] = 1;
          e_busy[d] = 0;
          e_sum[d]  = m_tot[d][7:0] & mask;
          e_co[d]   = m_tot[d][width_of(d)];
        end
      end else if (st_v[d]) begin
        m_run[d]  = 1;
        m_k[d]    = 0;
        m_tot[d]  = {1'b0, a_v[d] & mask} + {1'b0, b_v[d] & mask};
        e_busy[d] = 1; e_done[d] = 0; e_bv[d] = 0;
      end else begin
        e_busy[d] = 0; e_done[d] = 0; e_bv[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        check($sformatf("d%0d busy", d),      32'(busy_v[d]), 32'(e_busy[d]));
        check($sformatf("d%0d done", d),      32'(done_v[d]), 32'(e_done[d]));
        check($sformatf("d%0d bit_valid", d), 32'(bv_v[d]),   32'(e_bv[d]));
        check($sformatf("d%0d bit_out", d),   32'(bo_v[d]),   32'(e_bo[d]));
        check($sformatf("d%0d sum", d),       32'(sum_w[d]),  32'(e_sum[d]));
        check($sformatf("d%0d carry_out", d), 32'(co_v[d]),   32'(e_co[d]));
      end
      if (done_v[d] === 1'b1) done_cnt[d]++;
    end
    if (bv_v[0] === 1'b1) cap8 = {bo_v[0], cap8[7:1]};
  end

  // Called #1 after an edge; returns #1 after the edge that raises done.
  task automatic wait_done(input int d, output logic [7:0] s, output logic c, output int lat);
    bit found = 0;
    lat = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done_v[d] === 1'b1) found = 1;
    end
    if (!found) check($sformatf("d%0d done timeout", d), 32'(found), 32'(1));
    s = sum_w[d];
    c = co_v[d];
  endtask

  task automatic run_add(input int d, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] s, output logic c, output int lat);
    st_v[d] = 1'b1; a_v[d] = a; b_v[d] = b;
    @(posedge clk); #1;
    st_v[d] = 1'b0; a_v[d] = 8'($urandom); b_v[d] = 8'($urandom);
    wait_done(d, s, c, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s, ra, rb;
    logic [8:0] tot;
    logic       c;
    int         lat, dc;
    longint     t0;

    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; st_v[d] = 1'b0; a_v[d] = 8'h00; b_v[d] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    check("reset busy", 32'(busy_v[0]), 32'(0));
    check("reset done", 32'(done_v[0]), 32'(0));
    check("reset sum",  32'(sum8),      32'(0));
    check("reset carry", 32'(co_v[0]),  32'(0));

    run_add(0, 8'h00, 8'h00, s, c, lat);
    check("0+0 latency edges", 32'(lat), 32'(8));
    check("0+0 sum", 32'(s), 32'h00);
    check("0+0 carry", 32'(c), 32'(0));

    run_add(0, 8'h5A, 8'h33, s, c, lat);
    @(negedge clk); #1;
    check("5A+33 sum", 32'(s), 32'h8D);
    check("5A+33 carry", 32'(c), 32'(0));
    check("5A+33 serial bits", 32'(cap8), 32'h8D);

    run_add(0, 8'hFF, 8'h01, s, c, lat);
    check("FF+01 sum", 32'(s), 32'h00);
    check("FF+01 carry", 32'(c), 32'(1));
    run_add(0, 8'hFF, 8'hFF, s, c, lat);
    check("FF+FF sum", 32'(s), 32'hFE);
    check("FF+FF carry", 32'(c), 32'(1));
    repeat (2) begin @(posedge clk); #1; end

    // start pulsed mid-RUN must be ignored
    dc = done_cnt[0];
    st_v[0] = 1'b1; a_v[0] = 8'h12; b_v[0] = 8'h34;
    @(posedge clk); #1;
    st_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    st_v[0] = 1'b1; a_v[0] = 8'hAA; b_v[0] = 8'hBB;
    @(posedge clk); #1;
    st_v[0] = 1'b0;
    wait_done(0, s, c, lat);
    repeat (4) begin @(posedge clk); #1; end
    check("midrun start sum", 32'(s), 32'h46);
    check("midrun start done pulses", 32'(done_cnt[0] - dc), 32'(1));

    // reset 3 cycles into RUN aborts without done
    st_v[0] = 1'b1; a_v[0] = 8'h77; b_v[0] = 8'h11;
    @(posedge clk); #1;
    st_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    check("abort busy", 32'(busy_v[0]), 32'(0));
    check("abort bit_valid", 32'(bv_v[0]), 32'(0));
    check("abort sum", 32'(sum8), 32'(0));
    dc = done_cnt[0];
    repeat (12) begin @(posedge clk); #1; end
    check("abort no done", 32'(done_cnt[0] - dc), 32'(0));
    run_add(0, 8'h10, 8'h20, s, c, lat);
    check("10+20 sum", 32'(s), 32'h30);
    check("10+20 carry", 32'(c), 32'(0));

    // WIDTH=1 half-adder truth table
    run_add(1, 8'h00, 8'h00, s, c, lat);
    check("w1 0+0", 32'({c, s[0]}), 32'b00);
    run_add(1, 8'h00, 8'h01, s, c, lat);
    check("w1 0+1", 32'({c, s[0]}), 32'b01);
    run_add(1, 8'h01, 8'h00, s, c, lat);
    check("w1 1+0", 32'({c, s[0]}), 32'b01);
    run_add(1, 8'h01, 8'h01, s, c, lat);
    check("w1 1+1", 32'({c, s[0]}), 32'b10);
    t0 = cyc;
    run_add(1, 8'h01, 8'h00, s, c, lat);
    check("w1 back-to-back spacing", 32'(cyc - t0), 32'(2));
    check("w1 back-to-back sum", 32'({c, s[0]}), 32'b01);

    // randomized adds with random gaps (gap 0 means start in the DONE cycle)
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      tot = {1'b0, ra} + {1'b0, rb};
      run_add(0, ra, rb, s, c, lat);
      check("rand w8 sum", 32'(s), 32'(tot[7:0]));
      check("rand w8 carry", 32'(c), 32'(tot[8]));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1));
      tot = {1'b0, ra} + {1'b0, rb};
      run_add(1, ra, rb, s, c, lat);
      check("rand w1 result", 32'({c, s[0]}), 32'(tot[1:0]));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
